// File: rtl/fb_char_writer.sv
// 8x8 glyph writer for the 1-bpp framebuffer: draws characters and clears the screen through the RAM write port.
// Define FB_AUTOCLEAR_EN to zero the framebuffer automatically after every reset release.
module fb_char_writer #(
  parameter int COLS      = 80,
  parameter int TEXT_ROWS = 51,
  parameter int FB_WORDS  = 8192,
  parameter int ADDR_W    = 13
) (
  input  logic              CLK_25,
  input  logic              Reset_N,
  input  logic              CharValid,
  output logic              CharReady,
  input  logic [7:0]        CharCode,
  input  logic [6:0]        CharCol,
  input  logic [5:0]        CharRow,
  input  logic              ClearReq,
  output logic [31:0]       WrData,
  output logic [ADDR_W-1:0] WrAddress,
  output logic              WrEn,
  output logic              Busy,
  output logic              ErrPulse,
  output logic [2:0]        DbgState
);

  typedef enum logic [2:0] {IDLE, FETCH, WR0, WR1, CLEAR} stateT;

  localparam logic [6:0]        COLS_L    = 7'(COLS);
  localparam logic [5:0]        ROWS_L    = 6'(TEXT_ROWS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

`ifdef FB_AUTOCLEAR_EN
  localparam stateT RST_STATE = CLEAR;
  localparam logic  RST_READY = 1'b0;
`else
  localparam stateT RST_STATE = IDLE;
  localparam logic  RST_READY = 1'b1;
`endif

  stateT             state, stateNxt;
  logic [7:0]        codeQ;
  logic [6:0]        colQ;
  logic [5:0]        rowQ;
  logic [31:0]       glyphHi;
  logic [63:0]       glyph;
  logic [ADDR_W:0]   wr0Addr;
  logic              accept;
  logic              inRange;
  logic              wrEnNxt, errNxt;
  logic [31:0]       wrDataNxt;
  logic [ADDR_W-1:0] wrAddrNxt;

  // Packs glyph lines so that line k lands in bits [8k+7:8k].
  function automatic logic [63:0] g8(input logic [7:0] l0, l1, l2, l3, l4, l5, l6, l7);
    return {l7, l6, l5, l4, l3, l2, l1, l0};
  endfunction

  function automatic logic [63:0] glyphRom(input logic [7:0] code);
    case (code)
      8'h20:   return 64'h0;
      8'h30:   return g8(8'h3E, 8'h63, 8'h73, 8'h7B, 8'h6F, 8'h67, 8'h3E, 8'h00);
      8'h31:   return g8(8'h18, 8'h1C, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00);
      8'h32:   return g8(8'h1E, 8'h33, 8'h30, 8'h1C, 8'h06, 8'h33, 8'h3F, 8'h00);
      8'h33:   return g8(8'h1E, 8'h33, 8'h30, 8'h1C, 8'h30, 8'h33, 8'h1E, 8'h00);
      8'h34:   return g8(8'h38, 8'h3C, 8'h36, 8'h33, 8'h7F, 8'h30, 8'h78, 8'h00);
      8'h35:   return g8(8'h3F, 8'h03, 8'h1F, 8'h30, 8'h30, 8'h33, 8'h1E, 8'h00);
      8'h36:   return g8(8'h1C, 8'h06, 8'h03, 8'h1F, 8'h33, 8'h33, 8'h1E, 8'h00);
      8'h37:   return g8(8'h3F, 8'h33, 8'h30, 8'h18, 8'h0C, 8'h0C, 8'h0C, 8'h00);
      8'h38:   return g8(8'h1E, 8'h33, 8'h33, 8'h1E, 8'h33, 8'h33, 8'h1E, 8'h00);
      8'h39:   return g8(8'h1E, 8'h33, 8'h33, 8'h3E, 8'h30, 8'h18, 8'h0E, 8'h00);
      8'h41:   return g8(8'h0C, 8'h1E, 8'h33, 8'h33, 8'h3F, 8'h33, 8'h33, 8'h00);
      8'h42:   return g8(8'h3F, 8'h66, 8'h66, 8'h3E, 8'h66, 8'h66, 8'h3F, 8'h00);
      8'h43:   return g8(8'h3C, 8'h66, 8'h03, 8'h03, 8'h03, 8'h66, 8'h3C, 8'h00);
      8'h44:   return g8(8'h1F, 8'h36, 8'h66, 8'h66, 8'h66, 8'h36, 8'h1F, 8'h00);
      8'h45:   return g8(8'h7F, 8'h46, 8'h16, 8'h1E, 8'h16, 8'h46, 8'h7F, 8'h00);
      8'h46:   return g8(8'h7F, 8'h46, 8'h16, 8'h1E, 8'h16, 8'h06, 8'h0F, 8'h00);
      default: return g8(8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55);
    endcase
  endfunction

  // Handshake: a request transfers on a clock edge where CharValid and CharReady are both high
  // in IDLE and ClearReq is low; ClearReq has priority and the pending request waits for the next IDLE.
  assign accept  = (state == IDLE) && CharValid && CharReady && !ClearReq;
  assign inRange = (CharCol < COLS_L) && (CharRow < ROWS_L);
  assign glyph   = glyphRom(codeQ);
  assign wr0Addr = ((ADDR_W+1)'(rowQ) << 1) * (ADDR_W+1)'(COLS) + (ADDR_W+1)'(colQ);
  assign DbgState = state;

  always_comb begin
    stateNxt  = state;
    wrEnNxt   = 1'b0;
    wrDataNxt = WrData;
    wrAddrNxt = WrAddress;
    errNxt    = 1'b0;
    case (state)
      IDLE: begin
        if (ClearReq) begin
          stateNxt  = CLEAR;
          wrEnNxt   = 1'b1;
          wrAddrNxt = '0;
          wrDataNxt = '0;
        end else if (accept) begin
          if (inRange) stateNxt = FETCH;
          else         errNxt   = 1'b1;
        end
      end
      FETCH: begin
        stateNxt  = WR0;
        wrEnNxt   = 1'b1;
        wrAddrNxt = wr0Addr[ADDR_W-1:0];
        wrDataNxt = glyph[31:0];
      end
      WR0: begin
        stateNxt  = WR1;
        wrEnNxt   = 1'b1;
        wrAddrNxt = WrAddress + ADDR_W'(COLS);
        wrDataNxt = glyphHi;
      end
      WR1: stateNxt = IDLE;
      CLEAR: begin
        wrDataNxt = '0;
        // WrEn low inside CLEAR only happens right after an auto-clear reset: start at word 0.
        if (!WrEn) begin
          wrEnNxt   = 1'b1;
          wrAddrNxt = '0;
        end else if (WrAddress == LAST_ADDR) begin
          stateNxt = IDLE;
        end else begin
          wrEnNxt   = 1'b1;
          wrAddrNxt = WrAddress + ADDR_W'(1);
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_25 or negedge Reset_N) begin
    if (!Reset_N) begin
      state     <= RST_STATE;
      WrEn      <= 1'b0;
      WrData    <= '0;
      WrAddress <= '0;
      Busy      <= 1'b0;
      ErrPulse  <= 1'b0;
      CharReady <= RST_READY;
    end else begin
      state     <= stateNxt;
      WrEn      <= wrEnNxt;
      WrData    <= wrDataNxt;
      WrAddress <= wrAddrNxt;
      Busy      <= (stateNxt != IDLE);
      ErrPulse  <= errNxt;
      CharReady <= (stateNxt == IDLE);
    end
  end

  always_ff @(posedge CLK_25 or negedge Reset_N) begin
    if (!Reset_N) begin
      codeQ   <= '0;
      colQ    <= '0;
      rowQ    <= '0;
      glyphHi <= '0;
    end else begin
      if (accept) begin
        codeQ <= CharCode;
        colQ  <= CharCol;
        rowQ  <= CharRow;
      end
      if (state == FETCH) glyphHi <= glyph[63:32];
    end
  end

endmodule

// File: tb/tb_fb_char_writer.sv
// Randomized bench for fb_char_writer: a pixel-level framebuffer model predicts every RAM write
// and the cycle-by-cycle handshake; writes are matched in order against an expected queue.
module tb_fb_char_writer;

  localparam int W          = 13 + 32;
  localparam int CLEAR_CYC  = 8193;
`ifdef FB_AUTOCLEAR_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset_N;
  logic        CharValid, CharReady, ClearReq;
  logic [7:0]  CharCode;
  logic [6:0]  CharCol;
  logic [5:0]  CharRow;
  logic [31:0] WrData;
  logic [12:0] WrAddress;
  logic        WrEn, Busy, ErrPulse;
  logic [2:0]  DbgState;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  fb_char_writer dut (
    .CLK_25(clk), .Reset_N(Reset_N), .CharValid(CharValid), .CharReady(CharReady),
    .CharCode(CharCode), .CharCol(CharCol), .CharRow(CharRow), .ClearReq(ClearReq),
    .WrData(WrData), .WrAddress(WrAddress), .WrEn(WrEn), .Busy(Busy),
    .ErrPulse(ErrPulse), .DbgState(DbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: glyph line k of a character, straight from the font rules
  function automatic logic [7:0] ref_line(input logic [7:0] code, input int k);
    if (code == 8'h20) return 8'h00;
    if (code == 8'h31) begin
      case (k)
        1:       return 8'h1C;
        6:       return 8'h7E;
        7:       return 8'h00;
        default: return 8'h18;
      endcase
    end
    return (k % 2 == 0) ? 8'hAA : 8'h55;
  endfunction

  // Each character covers pixel lines row*8..row*8+7 at x = col*8; map them to words with
  // word = (line/4)*80 + x/8 and byte = line%4.
  task automatic push_draw(input logic [7:0] code, input int col, input int row);
    for (int h = 0; h < 2; h++) begin
      int line0 = row * 8 + h * 4;
      int addr  = (line0 / 4) * 80 + (col * 8) / 8;
      logic [31:0] d;
      for (int k = 0; k < 4; k++) d[8*k +: 8] = ref_line(code, (line0 + k) % 8);
      exp_q.push_back({13'(addr), d});
    end
  endtask

  task automatic push_clear();
    for (int a = 0; a < 8192; a++) exp_q.push_back({13'(a), 32'h0});
  endtask

  // scoreboard: every write seen must be the next expected one
  always @(negedge clk) begin
    if (Reset_N === 1'b1 && WrEn === 1'b1) begin
      if (exp_q.size() == 0) check_eq("unexpected_wr", WrEn, 1'b0);
      else check_eq("wr_addr_data", {WrAddress, WrData}, exp_q.pop_front());
    end
  end

  task automatic wait_ready(output int cyc);
    cyc = 1;
    while (CharReady !== 1'b1 && cyc < 10000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Called at a negedge with Reset_N low.
  task automatic release_reset();
    int cyc;
    if (AUTO) push_clear();
    Reset_N = 1'b1;
    @(negedge clk);
    if (AUTO) begin
      check_eq("auto_busy", Busy, 1'b1);
      check_eq("auto_ready", CharReady, 1'b0);
      check_eq("auto_wren", WrEn, 1'b1);
      wait_ready(cyc);
      check_eq("auto_clear_len", cyc, CLEAR_CYC);
    end else begin
      check_eq("post_rst_ready", CharReady, 1'b1);
      check_eq("post_rst_busy", Busy, 1'b0);
      check_eq("post_rst_wren", WrEn, 1'b0);
    end
  endtask

  // driver: one request presented for one cycle, handshake checked until CharReady returns
  task automatic draw(input logic [7:0] code, input int col, input int row);
    bit in_range = (col < 80) && (row < 51);
    if (in_range) push_draw(code, col, row);
    CharCode  = code;
    CharCol   = 7'(col);
    CharRow   = 6'(row);
    check_eq("ready_before", CharReady, 1'b1);
    CharValid = 1'b1;
    @(negedge clk);
    CharValid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (in_range) begin
        check_eq("draw_wren", WrEn, (c == 2 || c == 3));
        check_eq("draw_ready", CharReady, (c == 4));
        check_eq("draw_busy", Busy, (c != 4));
        check_eq("draw_err", ErrPulse, 1'b0);
      end else begin
        check_eq("oor_wren", WrEn, 1'b0);
        check_eq("oor_ready", CharReady, 1'b1);
        check_eq("oor_err", ErrPulse, (c == 1));
      end
      if (c < 4) @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    logic [7:0] code;
    Reset_N = 1'b1; CharValid = 1'b0; ClearReq = 1'b0;
    CharCode = '0; CharCol = '0; CharRow = '0;
    #1 Reset_N = 1'b0;
    #1;
    check_eq("rst_wren", WrEn, 1'b0);
    check_eq("rst_wrdata", WrData, 32'h0);
    check_eq("rst_wraddr", WrAddress, 13'h0);
    check_eq("rst_busy", Busy, 1'b0);
    check_eq("rst_err", ErrPulse, 1'b0);
    check_eq("rst_ready", CharReady, !AUTO);
    repeat (2) @(negedge clk);
    release_reset();

    // directed corners
    draw(8'h31, 5, 0);
    draw(8'h7A, 79, 50);
    draw(8'h20, 0, 0);
    draw(8'h31, 80, 0);
    draw(8'h31, 0, 51);
    draw(8'h41, 127, 63);

    // clear wins over a simultaneous draw; the held draw follows the clear
    push_clear();
    push_draw(8'h31, 2, 3);
    CharCode = 8'h31; CharCol = 7'd2; CharRow = 6'd3;
    CharValid = 1'b1; ClearReq = 1'b1;
    @(negedge clk);
    ClearReq = 1'b0;
    check_eq("clr_ready", CharReady, 1'b0);
    check_eq("clr_busy", Busy, 1'b1);
    check_eq("clr_err", ErrPulse, 1'b0);
    wait_ready(cyc);
    check_eq("clear_len", cyc, CLEAR_CYC);
    @(negedge clk);
    CharValid = 1'b0;
    check_eq("held_busy", Busy, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("held_ready", CharReady, 1'b1);

    // randomized draws, some out of range, some back to back
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: code = 8'h20;
        1: code = 8'h31;
        default: begin
          code = 8'($urandom_range(0, 255));
          if ((code >= 8'h30 && code <= 8'h39) || (code >= 8'h41 && code <= 8'h46)) code = 8'h7A;
        end
      endcase
      draw(code, $urandom_range(0, 85), $urandom_range(0, 55));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // reset during WR0 abandons the character
    push_draw(8'h31, 10, 7);
    CharCode = 8'h31; CharCol = 7'd10; CharRow = 6'd7;
    CharValid = 1'b1;
    @(negedge clk);
    CharValid = 1'b0;
    @(negedge clk);
    check_eq("mid_wr0_wren", WrEn, 1'b1);
    void'(exp_q.pop_back());
    #2 Reset_N = 1'b0;
    #1;
    check_eq("mid_rst_wren", WrEn, 1'b0);
    check_eq("mid_rst_busy", Busy, 1'b0);
    check_eq("mid_rst_ready", CharReady, !AUTO);
    @(negedge clk);
    release_reset();
    repeat (4) @(negedge clk);
    check_eq("after_rst_ready", CharReady, 1'b1);
    draw(8'h31, 5, 0);

    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fb_char_writer.md
Name: fb_char_writer

Overview:
- Front-end writer for the 1-bpp VGA framebuffer in ram2port. Accepts character draw and clear commands, looks up an 8x8 glyph and writes it through the RAM write port (WrData/WrAddress/WrEn).
- Replaces the hard-coded write sequencer; the scan-out/read side is unchanged.
- Memory layout matches scan-out:
  - Word address = (line/4)*80 + x/8.
  - Byte k of a word = line with line%4 == k.
  - Bit i of a byte = pixel x%8 == i (bit 0 leftmost).

Parameters:
- COLS, 80, text columns per row; also the word stride per 4-line band.
- TEXT_ROWS, 51, text rows that fit in the framebuffer (51*2*80 = 8160 words).
- FB_WORDS, 8192, words cleared by a clear command; fixes the RAM depth.
- ADDR_W, 13, RAM word-address width.

Ports:
- CLK_25  in  1  pixel/system clock, 25 MHz.
- Reset_N  in  1  asynchronous, active-low reset.
- CharValid  in  1  draw request valid.
- CharReady  out  1  block can accept a request. High only in IDLE.
- CharCode  in  8  ASCII code.
- CharCol  in  7  text column, 0..COLS-1.
- CharRow  in  6  text row, 0..TEXT_ROWS-1.
- ClearReq  in  1  clear-screen request, sampled in IDLE.
- WrData  out  32  RAM write data.
- WrAddress  out  ADDR_W  RAM word address.
- WrEn  out  1  RAM write enable.
- Busy  out  1  high in any state except IDLE.
- ErrPulse  out  1  one-cycle pulse when an out-of-range draw is dropped.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - WrEn=0, WrData=0, WrAddress=0, Busy=0, ErrPulse=0.
  - CharReady=1 (without FB_AUTOCLEAR_EN).
- All outputs are registered.
- FSM states: IDLE, FETCH, WR0, WR1, CLEAR.
- IDLE:
  - ClearReq=1 -> CLEAR, with the address counter at 0. ClearReq wins over a simultaneous CharValid; that CharValid is not accepted (CharReady is dropped in the same cycle).
  - Otherwise CharValid && CharReady accepts the request: code, column and row are latched.
  - Accepted request with CharCol >= COLS or CharRow >= TEXT_ROWS: dropped, ErrPulse=1 for the next cycle, stay in IDLE, no write.
  - Accepted in-range request -> FETCH.
- FETCH: registered glyph-ROM read of 8 lines (one cycle) -> WR0.
- WR0:
  - WrEn=1, WrAddress = (2*row)*COLS + col.
  - WrData bytes [7:0],[15:8],[23:16],[31:24] = glyph lines 0,1,2,3.
  - -> WR1.
- WR1:
  - WrEn=1, WrAddress = WR0 address + COLS.
  - Bytes = glyph lines 4..7.
  - -> IDLE.
- Draw timing: accept at cycle N; WrEn at N+2 and N+3; CharReady high again at N+4. Peak throughput is 1 char per 4 cycles.
- Address arithmetic: computed at ADDR_W+1 bits, then truncated. The maximum legal address is 8159, so no wrap occurs for legal inputs.
- CLEAR:
  - WrEn=1, WrData=0, WrAddress=counter, counter+1 every cycle.
  - After address FB_WORDS-1 is written -> IDLE.
  - Takes exactly FB_WORDS cycles. ClearReq and CharValid are ignored during CLEAR.
- Glyph ROM contents:
  - Codes 0x30-0x39, 0x41-0x46 and 0x20 come from the team 8x8 font table.
  - Space (0x20): all lines 0x00.
  - '1' (0x31): lines 0..7 = 18,1C,18,18,18,18,7E,00 (hex).
  - Any other code: lines alternate AA,55,AA,55,AA,55,AA,55.
- Reset mid-operation: WrEn drops immediately and the FSM returns to IDLE. A half-written character or partial clear is abandoned, with no resume.
- CharValid held high after acceptance is treated as a new request at the next IDLE.

Optional Feature:
- Macro: FB_AUTOCLEAR_EN.
- Defined: after reset release the FSM enters CLEAR automatically, with CharReady=0 and Busy=1 from the first clock. The framebuffer is zeroed before any draw.
- Undefined: the FSM comes out of reset in IDLE. RAM contents are whatever ram2port initialises to, and a clear happens only on ClearReq.

Test Plan:
- Draw '1' at col 5, row 0 -> write addr 5 data 0x18181C18, then addr 85 data 0x007E1818, on consecutive cycles starting 2 cycles after accept. CharReady=0 for exactly 4 cycles.
- Draw code 0x7A at col 79, row 50 -> addr 8079 data 0x55AA55AA, addr 8159 data 0x55AA55AA.
- Draw col 80 (or row 51) -> no WrEn. ErrPulse high exactly one cycle. CharReady stays 1.
- ClearReq and CharValid asserted in the same IDLE cycle -> 8192 writes of 0 at addresses 0..8191 in consecutive cycles. The character is drawn only after clear completes, with CharValid still held.
- Assert Reset_N low during WR0 of a draw -> WrEn=0 asynchronously. After release, no WR1 write occurs and CharReady=1.
- With FB_AUTOCLEAR_EN: release reset -> Busy=1 and 8192 zero writes begin on the first clock, then CharReady=1. Without the macro: CharReady=1 on the first clock.
